// File: rtl/asansor_pkg.sv
// Shared types and constants for the 4-floor elevator car controller.
package asansor_pkg;

    localparam int unsigned KAT_W      = 2;
    localparam int unsigned KAT_SAYISI = 4;

    typedef enum logic [1:0] {
        BEKLE,
        HAREKET,
        KAPI
    } durum_t;

    // Timer width covering both travel and door phases, at least 1 bit.
    function automatic int unsigned sayac_genislik(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/asansor_kontrol_sure_sayaci.sv
// Phase timer: up-counter with clear, enable and terminal-count compare.
// Wraps to zero on the enabled edge where it reaches the terminal count.
module sure_sayaci #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         temizle,
    input  logic         say,
    input  logic [W-1:0] son,
    output logic [W-1:0] deger,
    output logic         bitti
);

    assign bitti = (deger == son);

    // Count up while enabled, restart at terminal count or on clear/reset.
    always_ff @(posedge clk) begin
        if (rst || temizle) begin
            deger <= '0;
        end else if (say) begin
            deger <= bitti ? '0 : deger + W'(1);
        end
    end

endmodule

// File: rtl/asansor_kontrol.sv
// Elevator car controller: accepts a target floor, steps the car one floor
// per travel period, dwells with the door open, then returns to idle.
module asansor_kontrol #(
    parameter int unsigned KAT_SURESI  = 8,
    parameter int unsigned KAPI_SURESI = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] hedef_kat,
    input  logic       hedef_gecerli,
    output logic       hedef_hazir,
    output logic [1:0] bulundugu_kat,
    output logic       yukari,
    output logic       asagi,
    output logic       kapi_acik,
    output logic       vardi
);

    import asansor_pkg::*;

    localparam int unsigned SW = sayac_genislik(KAT_SURESI, KAPI_SURESI);

    durum_t           durum;
    logic [KAT_W-1:0] hedef;
    logic [KAT_W-1:0] kat;
    logic [KAT_W-1:0] sonraki_kat;
    logic [SW-1:0]    sure;
    logic [SW-1:0]    son;
    logic             sure_bitti;
    logic             sayac_temizle;
    logic             sayac_say;

    // One timer serves both phases; the terminal count follows the state.
    always_comb begin
        sayac_temizle = (durum == BEKLE);
        sayac_say     = (durum != BEKLE);
        son           = (durum == KAPI) ? SW'(KAPI_SURESI - 1) : SW'(KAT_SURESI - 1);
    end

    // Next floor in the direction of the target; never wraps since the
    // direction decode only steps toward a distinct in-range target.
    always_comb begin
        sonraki_kat = (hedef > kat) ? kat + KAT_W'(1) : kat - KAT_W'(1);
    end

    sure_sayaci #(
        .W(SW)
    ) u_sure (
        .clk     (clk),
        .rst     (rst),
        .temizle (sayac_temizle),
        .say     (sayac_say),
        .son     (son),
        .deger   (sure),
        .bitti   (sure_bitti)
    );

    // Car FSM with target and floor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum <= BEKLE;
            kat   <= '0;
            hedef <= '0;
        end else begin
            case (durum)
                BEKLE: begin
                    if (hedef_gecerli) begin
                        hedef <= hedef_kat;
                        durum <= (hedef_kat != kat) ? HAREKET : KAPI;
                    end
                end
                HAREKET: begin
                    if (sure_bitti) begin
                        kat <= sonraki_kat;
                        if (sonraki_kat == hedef) begin
                            durum <= KAPI;
                        end
                    end
                end
                KAPI: begin
                    if (sure_bitti) begin
                        durum <= BEKLE;
                    end
                end
                default: durum <= BEKLE;
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        hedef_hazir   = (durum == BEKLE);
        bulundugu_kat = kat;
        yukari        = (durum == HAREKET) && (hedef > kat);
        asagi         = (durum == HAREKET) && (hedef < kat);
        kapi_acik     = (durum == KAPI);
        vardi         = (durum == KAPI) && (sure == '0);
    end

endmodule

// File: tb/tb_asansor_kontrol.sv
// Self-checking bench for asansor_kontrol (KAT_SURESI=8, KAPI_SURESI=4).
module tb_asansor_kontrol;

    localparam int KS = 8;
    localparam int KP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] hedef_kat;
    logic       hedef_gecerli;
    logic       hedef_hazir;
    logic [1:0] bulundugu_kat;
    logic       yukari;
    logic       asagi;
    logic       kapi_acik;
    logic       vardi;

    int unsigned gecen  = 0;
    int unsigned toplam = 0;
    int          model_kat = 0;

    typedef struct {
        logic [1:0] hedef;
        bit         bozucu;
        int         sure;
    } vektor_t;

    vektor_t tablo [6];

    asansor_kontrol #(
        .KAT_SURESI  (KS),
        .KAPI_SURESI (KP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hedef_kat     (hedef_kat),
        .hedef_gecerli (hedef_gecerli),
        .hedef_hazir   (hedef_hazir),
        .bulundugu_kat (bulundugu_kat),
        .yukari        (yukari),
        .asagi         (asagi),
        .kapi_acik     (kapi_acik),
        .vardi         (vardi)
    );

    always #5 clk = ~clk;

    // {hazir, kat[1:0], yukari, asagi, kapi_acik, vardi}
    function automatic logic [6:0] gozlem();
        return {hedef_hazir, bulundugu_kat, yukari, asagi, kapi_acik, vardi};
    endfunction

    // Expected outputs n edges after accepting target t from floor f.
    function automatic logic [6:0] beklenen(input int f, input int t, input int n);
        int d;
        int yon;
        logic [1:0] k;
        d   = (t > f) ? t - f : f - t;
        yon = (t > f) ? 1 : -1;
        if (n < d * KS) begin
            k = 2'(f + yon * (n / KS));
            return {1'b0, k, 1'(t > f), 1'(t < f), 2'b00};
        end else if (n < d * KS + KP) begin
            return {1'b0, 2'(t), 2'b00, 1'b1, 1'(n == d * KS)};
        end
        return {1'b1, 2'(t), 4'b0000};
    endfunction

    task automatic kontrol(input string ad, input logic [6:0] gercek, input logic [6:0] bekle);
        toplam++;
        if (gercek === bekle) gecen++;
        else $display("FAIL %s: got %b expected %b (hazir,kat,yukari,asagi,kapi,vardi)", ad, gercek, bekle);
    endtask

    task automatic kontrol_int(input string ad, input int gercek, input int bekle);
        toplam++;
        if (gercek == bekle) gecen++;
        else $display("FAIL %s: got %0d expected %0d", ad, gercek, bekle);
    endtask

    // Issue one request and follow it cycle by cycle until ready returns.
    task automatic hizmet(input logic [1:0] t, input bit bozucu, input int beklenen_sure);
        int sure;
        sure = -1;
        kontrol("hazir_once", gozlem(), beklenen(model_kat, model_kat, KP));
        @(negedge clk);
        hedef_kat     = t;
        hedef_gecerli = 1'b1;
        @(posedge clk);
        #1;
        kontrol($sformatf("t%0d_E0", t), gozlem(), beklenen(model_kat, t, 0));
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bozucu && (n % 3 == 1)) begin
                hedef_gecerli = 1'b1;
                hedef_kat     = 2'd0;
            end else begin
                hedef_gecerli = 1'b0;
            end
            @(posedge clk);
            #1;
            kontrol($sformatf("t%0d_n%0d", t, n), gozlem(), beklenen(model_kat, t, n));
            if (hedef_hazir) begin
                sure = n;
                break;
            end
        end
        hedef_gecerli = 1'b0;
        if (beklenen_sure >= 0) kontrol_int($sformatf("sure_t%0d", t), sure, beklenen_sure);
        else if (sure < 0) kontrol_int("hazir_zaman_asimi", sure, 0);
        model_kat = t;
    endtask

    initial begin
        tablo[0] = '{hedef: 2'd3, bozucu: 1'b0, sure: 28};
        tablo[1] = '{hedef: 2'd1, bozucu: 1'b0, sure: 20};
        tablo[2] = '{hedef: 2'd2, bozucu: 1'b0, sure: 12};
        tablo[3] = '{hedef: 2'd2, bozucu: 1'b0, sure: 4};
        tablo[4] = '{hedef: 2'd0, bozucu: 1'b1, sure: 20};
        tablo[5] = '{hedef: 2'd3, bozucu: 1'b1, sure: 28};

        // Reset held for two cycles with a request pending.
        rst           = 1'b1;
        hedef_gecerli = 1'b1;
        hedef_kat     = 2'd3;
        repeat (2) begin
            @(posedge clk);
            #1;
            kontrol("reset", gozlem(), 7'b1_00_0000);
        end
        @(negedge clk);
        rst           = 1'b0;
        hedef_gecerli = 1'b0;
        @(posedge clk);
        #1;
        kontrol("reset_sonrasi", gozlem(), 7'b1_00_0000);

        foreach (tablo[i]) hizmet(tablo[i].hedef, tablo[i].bozucu, tablo[i].sure);

        // Reset while travelling from floor 0 toward 3, just after passing floor 1.
        hizmet(2'd0, 1'b0, 28);
        @(negedge clk);
        hedef_kat     = 2'd3;
        hedef_gecerli = 1'b1;
        @(posedge clk);
        #1;
        kontrol("orta_E0", gozlem(), beklenen(0, 3, 0));
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            hedef_gecerli = 1'b0;
            @(posedge clk);
            #1;
            kontrol($sformatf("orta_n%0d", n), gozlem(), beklenen(0, 3, n));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        kontrol("orta_reset", gozlem(), 7'b1_00_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        kontrol("orta_reset_sonrasi", gozlem(), 7'b1_00_0000);
        model_kat = 0;
        hizmet(2'd2, 1'b0, 20);

        // Randomised requests against the reference model.
        for (int i = 0; i < 20; i++) begin
            hizmet(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule

// File: doc/asansor_kontrol.md
# asansor_kontrol

Sequential car controller for the 4-floor elevator. It sits directly downstream of the floor-decision logic: it accepts the decided stop floor, drives the car one floor at a time with a per-floor travel timer, and holds the door open for a fixed dwell time. It then returns to idle. Its registered `bulundugu_kat` output is the current-floor input that the decision logic consumes, which closes the loop.

## Interface
Parameters:
- `KAT_SURESI`, default 8: clock cycles to travel one floor; must be ≥1.
- `KAPI_SURESI`, default 4: clock cycles the door stays open; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `hedef_kat`  in  2  target floor from the decision logic.
- `hedef_gecerli`  in  1  target-valid strobe.
- `hedef_hazir`  out  1  controller ready; high only in BEKLE.
- `bulundugu_kat`  out  2  current floor register; feeds the decision logic.
- `yukari`  out  1  motor up command.
- `asagi`  out  1  motor down command.
- `kapi_acik`  out  1  door-open command.
- `vardi`  out  1  one-cycle arrival pulse.

## Operation
- **Reset values** (at the first edge with `rst`=1):
  - state = BEKLE, `bulundugu_kat`=0, timer=0, target register=0.
  - `hedef_hazir`=1; `yukari`, `asagi`, `kapi_acik` and `vardi` are 0.
- **Reset mid-operation** aborts any move or door dwell immediately and returns the car to floor 0. No partial floor step completes.
- **Handshake:** a request is accepted on an edge where `hedef_gecerli`=1 and `hedef_hazir`=1. `hedef_kat` is latched into the target register on that edge.
  - `hedef_gecerli` is ignored in HAREKET and KAPI. There is no queueing and no retargeting mid-move.
- **States:**
  - BEKLE:
    - On accept with target ≠ floor: go to HAREKET, timer=0.
    - On accept with target = floor: go to KAPI, timer=0.
  - HAREKET:
    - `yukari` = (target > floor); `asagi` = (target < floor).
    - The timer counts 0..`KAT_SURESI`-1. On the edge where timer = `KAT_SURESI`-1, the floor steps ±1 and the timer clears.
    - If the new floor equals the target, go to KAPI on that same edge.
  - KAPI:
    - `kapi_acik`=1 and the timer counts 0..`KAPI_SURESI`-1.
    - On the edge where timer = `KAPI_SURESI`-1, go to BEKLE.
- `vardi` is high in the first KAPI cycle only (timer=0 in KAPI).
- **Invariants:**
  - `yukari` and `asagi` are never both 1.
  - `kapi_acik` is never 1 together with `yukari` or `asagi`.
  - The floor changes by at most 1 per step and never wraps: the 3→0 and 0→3 transitions are impossible.
- **Widths:**
  - The timer is $clog2(max(`KAT_SURESI`,`KAPI_SURESI`)) bits, minimum 1.
  - The floor step is 2-bit arithmetic. It is guarded by the direction decode, so it cannot overflow.

## Timing
- All outputs are functions of registers only; there is no combinational path from input to output.
- Let E0 be the accept edge and d = |target − floor|:
  - The floor changes at edges E0+k·`KAT_SURESI`, for k=1..d.
  - `kapi_acik` is high from edge E0+d·`KAT_SURESI` for exactly `KAPI_SURESI` cycles.
  - `hedef_hazir` rises at edge E0+d·`KAT_SURESI`+`KAPI_SURESI`.
- The same-floor case (d=0) follows the same formulas: door open from E0, ready again at E0+`KAPI_SURESI`.
- Back-to-back requests: a request held on the edge where `hedef_hazir` rises is not accepted. It is accepted on the next edge, since `hedef_hazir` is registered state.

## Structure
- Package `asansor_pkg` holds:
  - `durum_t` enum {BEKLE, HAREKET, KAPI};
  - `KAT_W`=2;
  - `KAT_SAYISI`=4.
- One sub-module, `sure_sayaci`: a parameterised up-counter with clear, enable and a terminal-count compare input. It is shared by the travel and door phases (a single instance, reloaded per phase).
- The top level contains the FSM, the target register, the floor register and the output decode.

## Test plan
All scenarios use `KAT_SURESI`=8 and `KAPI_SURESI`=4.
- **Reset:** hold `rst` for 2 cycles.
  - Required: floor=0, `hedef_hazir`=1, all other outputs 0, unaffected by `hedef_gecerli`.
- **Up 0→3:** accept at E0.
  - Floor 1/2/3 at E0+8/16/24; `yukari`=1 during E0..E0+24.
  - `vardi` for one cycle after E0+24; `kapi_acik` for 4 cycles; `hedef_hazir` at E0+28.
- **Down 3→1:**
  - `asagi`=1 for 16 cycles; floor 2 at E0+8, floor 1 at E0+16.
  - Door open for 4 cycles; `yukari` is never 1.
- **Same floor (floor=2, target=2):**
  - No motion; `vardi` and `kapi_acik` start at E0; `hedef_hazir` at E0+4.
- **Busy ignore:** pulse `hedef_gecerli` with target 0 during HAREKET and during KAPI.
  - Required: trajectory and timing identical to the unperturbed run.
- **Reset mid-move:** assert `rst` at floor 1 while heading to 3.
  - Required: the next edge gives floor=0 and BEKLE outputs; the next request is served normally.
